// File: rtl/clk_xfer_tx.sv
// clk_xfer_tx: 4-phase request/acknowledge transmitter.
// Presents a captured word on o_data, raises o_req after one setup cycle,
// and drops it once the synchronized acknowledge arrives or the wait
// limit expires. The acknowledge comes from another clock domain.
module clk_xfer_tx #(
    parameter int WIDTH   = 8,
    parameter int STAGES  = 3,
    parameter int TIMEOUT = 1023
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_valid,
    output logic             o_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_req,
    input  logic             i_ack,
    output logic             o_busy,
    output logic             o_err
);

    // Counter wide enough to hold TIMEOUT; a disabled timeout still needs one bit.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // The timeout fires on the edge that would bring the counter up to TIMEOUT.
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        REQ   = 2'd2,
        DROP  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [STAGES-1:0]  sync_q;
    logic               ack_s;
    logic               req_q, req_d;
    logic               err_q, err_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               cnt_hit;

    // Acknowledge synchronizer; only the last flop feeds the FSM.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) sync_q <= '0;
        else          sync_q <= {sync_q[STAGES-2:0], i_ack};
    end

    assign ack_s   = sync_q[STAGES-1];
    assign cnt_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    // State, handshake and data registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            err_q   <= err_d;
            data_q  <= data_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: acknowledge takes precedence over the timeout.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        err_d   = err_q;
        data_d  = data_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (i_valid) begin
                    data_d  = i_data;
                    err_d   = 1'b0;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                req_d   = 1'b1;
                cnt_d   = '0;
                state_d = REQ;
            end
            REQ: begin
                cnt_d = cnt_q + CW'(1);
                if (ack_s) begin
                    req_d   = 1'b0;
                    state_d = DROP;
                end else if (cnt_hit) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = DROP;
                end
            end
            DROP: begin
                if (!ack_s) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_ready = (state_q == IDLE);
    assign o_busy  = (state_q != IDLE);
    assign o_req   = req_q;
    assign o_err   = err_q;
    assign o_data  = data_q;

endmodule

// File: tb/tb_clk_xfer_tx.sv
// Bench for clk_xfer_tx: a scoreboard holds words as they are accepted,
// a monitor checks o_data on every o_req rise, and the main sequence
// checks latencies, timeout, stuck-ack, collision and reset behaviour.
module tb_clk_xfer_tx;

    localparam int STG = 3;
    localparam int TO  = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic [7:0] odata;
    logic       req;
    logic       ack;
    logic       busy;
    logic       err;
    logic       rx_auto;
    logic       ack_man;
    logic       ack_auto;

    int         total = 0;
    int         bad   = 0;
    int         sent  = 0;
    int         rises = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    assign ack = rx_auto ? ack_auto : ack_man;

    clk_xfer_tx #(.WIDTH(8), .STAGES(STG), .TIMEOUT(TO)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .i_data (data),
        .i_valid(valid),
        .o_ready(ready),
        .o_data (odata),
        .o_req  (req),
        .i_ack  (ack),
        .o_busy (busy),
        .o_err  (err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Receiver model: raise ack on the second sampled cycle of o_req, drop after o_req falls.
    initial begin
        int dly;
        dly = 0;
        ack_auto = 1'b0;
        forever begin
            @(negedge clk);
            if (!req) begin
                ack_auto = 1'b0;
                dly = 0;
            end else if (!ack_auto) begin
                dly++;
                if (dly >= 2) ack_auto = 1'b1;
            end
        end
    end

    // Monitor: every o_req rise must present the oldest accepted word.
    initial begin
        logic       req_prev;
        logic [7:0] e;
        req_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n && req && !req_prev) begin
                rises++;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL sb_unexpected: got %0h want none", odata);
                end else begin
                    e = exp_q.pop_front();
                    if (odata !== e) begin
                        bad++;
                        $display("FAIL sb_data: got %0h want %0h", odata, e);
                    end
                end
            end
            req_prev = req;
        end
    end

    // Offer a word and wait for its accept edge; optionally check o_data holds prev meanwhile.
    task automatic send(input logic [7:0] d, input logic [7:0] prev, input bit chk_prev);
        int n;
        n = 0;
        data  = d;
        valid = 1'b1;
        @(negedge clk);
        while (!ready && n < 100) begin
            if (chk_prev) chk("data_hold", odata, prev);
            n++;
            @(negedge clk);
        end
        if (!ready) begin
            bad++;
            total++;
            $display("FAIL accept_timeout: got ready=0 want ready=1");
            valid = 1'b0;
            return;
        end
        exp_q.push_back(d);
        sent++;
        @(posedge clk);
        #1;
    endtask

    // Count edges until o_req low (which=0) or o_ready high (which=1), bounded.
    task automatic edges_until(input int which, output int n);
        n = 0;
        while (((which == 0) ? (req !== 1'b0) : (ready !== 1'b1)) && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic basic(input logic [7:0] d);
        int n;
        rx_auto = 1'b1;
        send(d, 8'h00, 1'b0);
        valid = 1'b0;
        chk("b_data", odata, d);
        chk("b_ready0", ready, 0);
        chk("b_req_setup", req, 0);
        chk("b_busy", busy, 1);
        @(posedge clk); #1;
        chk("b_req_rise", req, 1);
        edges_until(0, n);
        chk("b_req_edges", n, 5);
        chk("b_drop_ready", ready, 0);
        edges_until(1, n);
        chk("b_drop_edges", n, 4);
        chk("b_err", err, 0);
        chk("b_data_keep", odata, d);
    endtask

    initial begin
        int n;
        rst_n   = 1'b0;
        valid   = 1'b0;
        data    = 8'h00;
        rx_auto = 1'b1;
        ack_man = 1'b0;
        #12;
        chk("rst_ready", ready, 1);
        chk("rst_req", req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_data", odata, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic transfer
        basic(8'hA5);

        // Back-to-back with i_valid held high
        rx_auto = 1'b1;
        send(8'h01, 8'h00, 1'b0);
        send(8'h02, 8'h01, 1'b1);
        valid = 1'b0;
        chk("b2b_data2", odata, 8'h02);
        edges_until(1, n);

        // Timeout with ack held low
        rx_auto = 1'b0;
        ack_man = 1'b0;
        send(8'h3C, 8'h00, 1'b0);
        valid = 1'b0;
        @(posedge clk); #1;
        chk("to_req_rise", req, 1);
        edges_until(0, n);
        chk("to_cycles", n, TO);
        chk("to_err", err, 1);
        chk("to_drop", ready, 0);
        @(posedge clk); #1;
        chk("to_idle", ready, 1);
        chk("to_err_sticky", err, 1);
        rx_auto = 1'b1;
        send(8'h77, 8'h00, 1'b0);
        valid = 1'b0;
        chk("to_err_clear", err, 0);
        edges_until(1, n);

        // Stuck ack before accept
        rx_auto = 1'b0;
        ack_man = 1'b1;
        repeat (STG + 1) @(posedge clk);
        #1;
        send(8'h5A, 8'h00, 1'b0);
        valid = 1'b0;
        chk("st_setup_req", req, 0);
        @(posedge clk); #1;
        chk("st_req_rise", req, 1);
        @(posedge clk); #1;
        chk("st_req_fall", req, 0);
        chk("st_err", err, 0);
        repeat (5) begin
            @(posedge clk); #1;
            chk("st_hold_drop", ready, 0);
        end
        @(negedge clk) ack_man = 1'b0;
        edges_until(1, n);
        chk("st_release", n, STG + 1);

        // Ack arrives on the same edge as the timeout
        ack_man = 1'b0;
        send(8'hC3, 8'h00, 1'b0);
        valid = 1'b0;
        repeat (14) @(negedge clk);
        ack_man = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("col_req_hold", req, 1);
        @(posedge clk); #1;
        chk("col_req_fall", req, 0);
        chk("col_err", err, 0);
        chk("col_drop", busy, 1);
        @(negedge clk) ack_man = 1'b0;
        edges_until(1, n);
        chk("col_release", n, STG + 1);

        // Reset in the middle of REQ
        send(8'h99, 8'h00, 1'b0);
        valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_req", req, 0);
        chk("mr_busy", busy, 0);
        chk("mr_err", err, 0);
        chk("mr_ready", ready, 1);
        chk("mr_data", odata, 0);
        @(negedge clk) rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("mr_no_replay", req, 0);
        end
        basic(8'h3E);

        chk("sb_empty", exp_q.size(), 0);
        chk("sb_rises", rises, sent);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/clk_xfer_tx.md
CLK_XFER_TX -- requirements
Module: clk_xfer_tx

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, data word width in bits.
REQ-002 The module SHALL have parameter STAGES, default 3, depth of the ack synchronizer in flip-flops (>= 2).
REQ-003 The module SHALL have parameter TIMEOUT, default 1023, the REQ-state wait limit in cycles (0 disables the timeout).
REQ-004 i_clk  input  1  domain clock, all state on rising edge.
REQ-005 i_rst_n  input  1  reset, asynchronous, active-low.
REQ-006 i_data  input  WIDTH  word to transmit, sampled on accept.
REQ-007 i_valid  input  1  upstream offers i_data.
REQ-008 o_ready  output  1  module can accept a word this cycle.
REQ-009 o_data  output  WIDTH  word presented to the external receiver.
REQ-010 o_req  output  1  4-phase request to the external receiver, registered.
REQ-011 i_ack  input  1  4-phase acknowledge from the receiver, asynchronous to i_clk.
REQ-012 o_busy  output  1  transfer in progress (state != IDLE).
REQ-013 o_err  output  1  sticky flag: last transfer timed out.

Function
REQ-014 i_ack SHALL pass through a STAGES-deep flip-flop chain; only the chain output (ack_s) SHALL be used by logic.
REQ-015 The FSM SHALL have states IDLE, SETUP, REQ, DROP.
REQ-016 o_ready SHALL be 1 exactly when the state is IDLE, combinationally from the state register.
REQ-017 Accept SHALL occur on a rising edge with i_valid=1 and o_ready=1; at that edge o_data <= i_data, o_err <= 0, state -> SETUP.
REQ-018 SETUP SHALL last exactly one cycle, with o_req=0, giving o_data one full cycle of setup before o_req rises; state -> REQ.
REQ-019 On entry to REQ, o_req SHALL be 1; on the first edge in REQ with ack_s=1, o_req <= 0 and state -> DROP.
REQ-020 In DROP, with o_req=0, the FSM SHALL wait; on the first edge with ack_s=0, state -> IDLE.
REQ-021 o_data SHALL remain unchanged from accept until the next accept, including through IDLE.
REQ-022 A cycle counter SHALL clear on REQ entry and increment each cycle in REQ, sized to hold TIMEOUT.
REQ-023 If TIMEOUT != 0 and the counter reaches TIMEOUT while ack_s=0 in REQ, the module SHALL set o_req <= 0 and o_err <= 1, and state -> DROP.
REQ-024 If ack_s=1 and the counter reaches TIMEOUT on the same edge, the acknowledge SHALL win and o_err SHALL stay 0.
REQ-025 DROP SHALL have no timeout, so a new transfer is never started while ack_s=1.
REQ-026 i_valid while not IDLE SHALL be ignored, with no data captured.
REQ-027 ack_s=1 already present in IDLE or SETUP SHALL have no effect until REQ, where it completes REQ on the first REQ edge.
REQ-028 Accept-to-o_req-rise latency SHALL be 2 edges; ack_s-high to o_req-fall latency SHALL be 1 edge; i_ack to ack_s latency SHALL be STAGES edges.

Reset
REQ-029 While i_rst_n=0, independent of i_clk, the module SHALL hold: state=IDLE, o_req=0, o_data=0, o_err=0, counter=0, synchronizer chain=0, o_busy=0, o_ready=1.
REQ-030 Reset asserted mid-transfer SHALL abort immediately (o_req=0); after release the FSM SHALL start from IDLE with no handshake replay.

Verification
REQ-031 Basic transfer (WIDTH=8, STAGES=3): accept 0xA5 at edge 0, receiver raises i_ack 2 cycles after o_req -> o_data=0xA5 from edge 0, o_req=1 after edge 1, o_req=0 one edge after ack_s=1, o_ready=1 one edge after ack_s=0, o_err=0.
REQ-032 Back-to-back: i_valid held high with 0x01 then 0x02 -> second word accepted only in IDLE, o_data=0x01 stays stable until that accept, no word lost or duplicated.
REQ-033 Timeout (TIMEOUT=16): i_ack held 0 -> o_req falls after 16 cycles in REQ, o_err=1, FSM returns to IDLE; next accept clears o_err.
REQ-034 Stuck ack: i_ack forced 1 before accept -> REQ completes on its first edge; FSM holds DROP with o_ready=0 until i_ack=0 plus STAGES edges.
REQ-035 Reset mid-REQ: i_rst_n pulled low between edges -> o_req, o_busy, o_err=0 immediately, without a clock edge; a transfer after release behaves as in REQ-031.
REQ-036 Collision: ack_s rises on the same edge the counter hits TIMEOUT -> DROP entered, o_err=0.
